// File: rtl/rr_fifo_arbiter_pkg.sv
// rr_fifo_arbiter_pkg: FSM state encoding and clog2 helper shared by the arbiter files
package rr_fifo_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    PUSH = 2'd3
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_fifo_arbiter_pick.sv
// rr_pick: combinational round-robin selector, first requester strictly after last wins
module rr_pick import rr_fifo_arbiter_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   last,
  output logic [clog2(N)-1:0]   idx,
  output logic                  any
);
  localparam int GW = clog2(N);
  logic [GW-1:0] j;
  // walk from lowest to highest priority so the closest requester after last is written last
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = GW'((int'(last) + i) % N);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin mover from NSRC source FIFOs into one downstream FIFO.
// Optional RR_ARB_STATS_EN adds per-source saturating push counters on grant_cnt.
module rr_fifo_arbiter import rr_fifo_arbiter_pkg::*; #(
  parameter int BITNUMBER = 6,
  parameter int NSRC      = 4,
  parameter int WAIT_MAX  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSRC-1:0]           src_empty,
  input  logic [NSRC-1:0]           src_valid,
  input  logic [NSRC*BITNUMBER-1:0] src_data,
  input  logic                      dst_pause,
  input  logic                      dst_full,
  output logic [NSRC-1:0]           src_pop,
  output logic                      dst_push,
  output logic [BITNUMBER-1:0]      dst_data,
  output logic [clog2(NSRC)-1:0]    grant,
  output logic                      busy,
  output logic                      timeout_err
`ifdef RR_ARB_STATS_EN
  ,output logic [NSRC*8-1:0]        grant_cnt
`endif
);
  localparam int GW = clog2(NSRC);
  localparam int CW = clog2(WAIT_MAX + 1);
  state_t state, state_n;
  logic [GW-1:0] grant_n, last_grant, last_grant_n, pick;
  logic any_req;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic [BITNUMBER-1:0] dst_data_n;
  logic [NSRC-1:0] src_pop_n;
  logic dst_push_n, timeout_n;
  rr_pick #(.N(NSRC)) u_pick (
    .req  (~src_empty),
    .last (last_grant),
    .idx  (pick),
    .any  (any_req)
  );
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_grant_n = last_grant;
    wait_cnt_n = wait_cnt;
    dst_data_n = dst_data;
    src_pop_n = '0;
    dst_push_n = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: if (!dst_pause && !dst_full && any_req) begin
        state_n = POP;
        grant_n = pick;
        src_pop_n = NSRC'(1) << pick;
      end
      POP: begin
        state_n = WAIT;
        wait_cnt_n = '0;
      end
      WAIT: if (src_valid[grant]) begin
        dst_data_n = src_data[int'(grant)*BITNUMBER +: BITNUMBER];
        state_n = PUSH;
      end else begin
        wait_cnt_n = wait_cnt + 1'b1;
        if (wait_cnt_n == CW'(WAIT_MAX)) begin
          timeout_n = 1'b1;
          last_grant_n = grant;
          state_n = IDLE;
        end
      end
      // a committed word waits only on full, never on pause
      PUSH: if (!dst_full) begin
        dst_push_n = 1'b1;
        last_grant_n = grant;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(NSRC - 1);
      wait_cnt <= '0;
      dst_data <= '0;
      src_pop <= '0;
      dst_push <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= last_grant_n;
      wait_cnt <= wait_cnt_n;
      dst_data <= dst_data_n;
      src_pop <= src_pop_n;
      dst_push <= dst_push_n;
      timeout_err <= timeout_n;
    end
  end
`ifdef RR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) grant_cnt <= '0;
    else if (state == PUSH && !dst_full && grant_cnt[int'(grant)*8 +: 8] != 8'hff)
      grant_cnt[int'(grant)*8 +: 8] <= grant_cnt[int'(grant)*8 +: 8] + 8'd1;
  end
`endif
endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// tb_rr_fifo_arbiter: directed checks of arbitration order, stalls, timeout, pause and reset
module tb_rr_fifo_arbiter;
  localparam int BW = 6;
  localparam int NS = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NS-1:0] src_empty = '1;
  logic [NS-1:0] src_valid = '0;
  logic [NS*BW-1:0] src_data = '0;
  logic dst_pause = 1'b0;
  logic dst_full = 1'b0;
  logic [NS-1:0] src_pop;
  logic dst_push;
  logic [BW-1:0] dst_data;
  logic [1:0] grant;
  logic busy;
  logic timeout_err;
  int errors = 0;
  int checks = 0;
  int cnt[NS];
  logic [NS-1:0] last_pop = '0;
  logic [NS-1:0] vmask = '1;
  int multi = 0;
  logic [BW-1:0] pq[$];
  logic [1:0] gq[$];
  rr_fifo_arbiter #(.BITNUMBER(BW), .NSRC(NS), .WAIT_MAX(7)) dut (
    .clk(clk), .reset(reset), .src_empty(src_empty), .src_valid(src_valid),
    .src_data(src_data), .dst_pause(dst_pause), .dst_full(dst_full),
    .src_pop(src_pop), .dst_push(dst_push), .dst_data(dst_data),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic upd();
    for (int i = 0; i < NS; i++) src_empty[i] = (cnt[i] == 0);
  endtask
  // source model: valid one cycle after the pop strobe, words drained by pops
  task automatic tick();
    @(posedge clk);
    #1;
    src_valid = last_pop & vmask;
    last_pop = src_pop;
    if ($countones(src_pop) > 1) multi++;
    for (int i = 0; i < NS; i++) if (src_pop[i] && cnt[i] > 0) cnt[i]--;
    upd();
    if (dst_push) begin
      pq.push_back(dst_data);
      gq.push_back(grant);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    src_valid = '0;
    last_pop = '0;
    pq.delete();
    gq.delete();
  endtask
  task automatic set_src(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    upd();
  endtask
  initial begin
    set_src(0, 0, 0, 0);
    do_reset();
    chk("rst_pop", src_pop, 0);
    chk("rst_push", dst_push, 0);
    chk("rst_data", dst_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0);
    // single source 2 holding 0x15
    src_data = {6'h04, 6'h15, 6'h02, 6'h01};
    set_src(0, 0, 1, 0);
    tick();
    chk("s2_pop", src_pop, 4'b0100);
    chk("s2_grant_pop", grant, 2);
    chk("s2_busy", busy, 1);
    tick();
    chk("s2_pop_once", src_pop, 0);
    tick();
    chk("s2_nopush_yet", dst_push, 0);
    tick();
    chk("s2_push", dst_push, 1);
    chk("s2_data", dst_data, 6'h15);
    chk("s2_grant", grant, 2);
    tick();
    chk("s2_idle_pop", src_pop, 0);
    chk("s2_idle_busy", busy, 0);
    // four sources, source 0 holding a second word
    do_reset();
    src_data = {6'h04, 6'h03, 6'h02, 6'h01};
    set_src(2, 1, 1, 1);
    for (int k = 0; k < 22; k++) tick();
    chk("rr_count", pq.size(), 5);
    if (pq.size() == 5) begin
      chk("rr_w0", pq[0], 6'h01);
      chk("rr_w1", pq[1], 6'h02);
      chk("rr_w2", pq[2], 6'h03);
      chk("rr_w3", pq[3], 6'h04);
      chk("rr_w4", pq[4], 6'h01);
      chk("rr_g4", gq[4], 0);
    end
    // downstream full for 5 cycles while in PUSH
    do_reset();
    src_data = {6'h04, 6'h03, 6'h2a, 6'h01};
    set_src(0, 1, 0, 0);
    tick();
    chk("full_pop", src_pop, 4'b0010);
    tick();
    tick();
    dst_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("full_nopush", dst_push, 0);
      chk("full_hold", dst_data, 6'h2a);
    end
    dst_full = 1'b0;
    tick();
    chk("full_push", dst_push, 1);
    chk("full_data", dst_data, 6'h2a);
    // valid never arrives: timeout after WAIT_MAX cycles in WAIT
    do_reset();
    vmask = '0;
    set_src(2, 1, 0, 0);
    tick();
    chk("tmo_pop", src_pop, 4'b0001);
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("tmo_early", timeout_err, 0);
    end
    tick();
    chk("tmo_pulse", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    tick();
    chk("tmo_once", timeout_err, 0);
    chk("tmo_next_pop", src_pop, 4'b0010);
    chk("tmo_next_grant", grant, 1);
    chk("tmo_nopush", pq.size(), 0);
    vmask = '1;
    // pause blocks new pops but not a word in flight
    do_reset();
    src_data = {6'h04, 6'h03, 6'h02, 6'h01};
    set_src(1, 1, 1, 1);
    dst_pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pause_nopop", src_pop, 0);
    end
    dst_pause = 1'b0;
    tick();
    chk("pause_pop", src_pop, 4'b0001);
    dst_pause = 1'b1;
    tick();
    tick();
    tick();
    chk("pause_push", dst_push, 1);
    chk("pause_data", dst_data, 6'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pause_hold", src_pop, 0);
    end
    dst_pause = 1'b0;
    // reset during WAIT restores source 0 priority and drops the word
    do_reset();
    set_src(2, 2, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("rw_push0", dst_push, 1);
    chk("rw_grant0", grant, 0);
    tick();
    chk("rw_pop1", src_pop, 4'b0010);
    vmask = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rw_pop", src_pop, 0);
    chk("rw_push", dst_push, 0);
    chk("rw_data", dst_data, 0);
    chk("rw_grant", grant, 0);
    chk("rw_busy", busy, 0);
    chk("rw_tmo", timeout_err, 0);
    reset = 1'b0;
    vmask = '1;
    pq.delete();
    tick();
    chk("rw_first_pop", src_pop, 4'b0001);
    chk("rw_first_grant", grant, 0);
    tick();
    chk("rw_no_stale_push", pq.size(), 0);
    chk("onehot", multi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
